// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply, restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              Flush,
  input  logic              WriteHI,
  input  logic              WriteLO,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int W2 = 2 * DATA_W;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic              neg_q, neg_d;
  logic              nrem_q, nrem_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              sgn_a, sgn_b;
  logic [DATA_W:0]   sum, rem_sh, diff;
  logic [W2-1:0]     prod;
  logic [DATA_W-1:0] quo, rem;

  always_comb begin
    sgn_a  = !Op[0] && OperandA[DATA_W-1];
    sgn_b  = !Op[0] && OperandB[DATA_W-1];
    sum    = {1'b0, acc_q[W2-1:DATA_W]}
           + (acc_q[0] ? {1'b0, a_q} : '0);
    rem_sh = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, b_q};
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem    = nrem_q ? -acc_q[W2-1:DATA_W]
                    : acc_q[W2-1:DATA_W];

    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dz_d    = dz_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          div_d  = Op[1];
          neg_d  = sgn_a ^ sgn_b;
          nrem_d = sgn_a;
          a_d    = sgn_a ? -OperandA : OperandA;
          b_d    = sgn_b ? -OperandB : OperandB;
          cnt_d  = '0;
          dz_d   = Op[1] && (OperandB == '0);
          if (dz_d) begin
            acc_d   = {OperandA, {DATA_W{1'b1}}};
            state_d = FIX;
          end else begin
            acc_d   = Op[1] ? {{DATA_W{1'b0}}, a_d}
                            : {{DATA_W{1'b0}}, b_d};
            state_d = CALC;
          end
        end else if (!Start) begin
          if (WriteHI) hi_d = WrData;
          if (WriteLO) lo_d = WrData;
        end
      end
      CALC: begin
        if (div_q) begin
          // negative difference means restore (keep shifted remainder)
          acc_d = diff[DATA_W]
            ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
            : {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = {sum, acc_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          hi_d = acc_q[W2-1:DATA_W];
          lo_d = acc_q[DATA_W-1:0];
        end else if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[W2-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (Flush && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
